// File: rtl/spi_hmc7044_slave_if.sv
// -----------------------------------------------------------------------------
// spi_hmc7044_slave_if
// Bundles the SPI pins and the write/read/error strobes of the HMC7044
// configuration-port model.
//   master modport : drives spi_clk/cs/spi_mosi, observes miso and strobes
//   slave  modport : observes SPI pins, drives spi_miso and the strobes
// Signals:
//   spi_clk   SPI clock, CPOL=0
//   cs        chip select, active-low
//   spi_mosi  master data, MSB first
//   spi_miso  read data from the responder (0 when idle)
//   wr_vld    one-cycle pulse per committed write frame
//   wr_addr   address of the last write (held)
//   wr_data   data of the last write (held)
//   rd_vld    one-cycle pulse when a read data phase starts
//   frame_err one-cycle pulse per malformed frame
// -----------------------------------------------------------------------------
interface spi_hmc7044_slave_if;
    logic        spi_clk;
    logic        cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic        wr_vld;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_vld;
    logic        frame_err;

    modport master (
        output spi_clk, cs, spi_mosi,
        input  spi_miso, wr_vld, wr_addr, wr_data, rd_vld, frame_err
    );

    modport slave (
        input  spi_clk, cs, spi_mosi,
        output spi_miso, wr_vld, wr_addr, wr_data, rd_vld, frame_err
    );
endinterface

// File: rtl/spi_hmc7044_slave.sv
// -----------------------------------------------------------------------------
// spi_hmc7044_slave
// Board-side model of the HMC7044 SPI configuration port. The SPI pins are
// oversampled in the clk domain (clk >= 8x spi_clk) and decoded as 24-bit
// frames: bit23 R/W (1 = read), bits22:21 W1:W0 (must be 00), bits20:8
// address, bits7:0 data. Writes update an internal register file and are
// reported on wr_vld/wr_addr/wr_data; reads return register contents on
// spi_miso (changes on falling spi_clk, MSB first).
// Parameters:
//   REG_DEPTH  implemented registers, address 0..REG_DEPTH-1 (<= 8192)
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   bus        spi_hmc7044_slave_if.slave (SPI pins + strobes)
// -----------------------------------------------------------------------------
module spi_hmc7044_slave #(
    parameter int unsigned REG_DEPTH = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spi_hmc7044_slave_if.slave        bus
);

    localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Input conditioning: [0],[1] synchronizer, [2] history for edge detect.
    logic [2:0] sclk_s_q;
    logic [2:0] cs_s_q;
    logic [1:0] mosi_s_q;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;

    assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
    assign sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];
    assign cs_rise   = cs_s_q[1] & ~cs_s_q[2];
    assign cs_fall   = ~cs_s_q[1] & cs_s_q[2];
    // Same stage as the spi_clk rise, so data stays aligned with its edge.
    assign mosi_s    = mosi_s_q[1];

    logic [1:0]  state_q,   state_d;
    logic [22:0] sh_q,      sh_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        over_q,    over_d;
    logic        errs_q,    errs_d;
    logic [7:0]  msh_q,     msh_d;
    logic        miso_q,    miso_d;
    logic        wr_vld_q,  wr_vld_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_vld_q,  rd_vld_d;
    logic        ferr_q,    ferr_d;
    logic        mem_we;

    logic [7:0]  mem_q [REG_DEPTH];

    // Full frame view including the bit arriving this cycle; only 23 bits
    // need storing because the 24th is consumed the cycle it arrives.
    logic [23:0] shift_in;
    logic        rd_in_range;
    logic        wr_in_range;
    logic [7:0]  rd_byte;

    assign shift_in    = {sh_q, mosi_s};
    // At the 16th bit the address sits in shift_in[12:0].
    assign rd_in_range = (32'(shift_in[12:0]) < REG_DEPTH);
    assign wr_in_range = (32'(shift_in[20:8]) < REG_DEPTH);
    assign rd_byte     = rd_in_range ? mem_q[shift_in[AW-1:0]] : 8'h00;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        over_d    = over_q;
        errs_d    = errs_q;
        msh_d     = msh_q;
        miso_d    = miso_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_vld_d  = 1'b0;
        ferr_d    = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    sh_d    = '0;
                    cnt_d   = '0;
                    over_d  = 1'b0;
                    errs_d  = 1'b0;
                    msh_d   = '0;
                    miso_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (sclk_rise) begin
                    sh_d  = shift_in[22:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd15 && shift_in[15]) begin
                        // Read header complete: present bit7 right away.
                        if (shift_in[14:13] == 2'b00) begin
                            msh_d    = rd_byte;
                            miso_d   = rd_byte[7];
                            rd_vld_d = 1'b1;
                            state_d  = ST_RDATA;
                        end else begin
                            ferr_d  = 1'b1;
                            errs_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else if (cnt_q == 5'd23) begin
                        if (shift_in[22:21] == 2'b00) begin
                            wr_vld_d  = 1'b1;
                            wr_addr_d = shift_in[20:8];
                            wr_data_d = shift_in[7:0];
                            mem_we    = wr_in_range;
                        end else begin
                            ferr_d = 1'b1;
                            errs_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RDATA: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        state_d = ST_DONE;
                    end
                end else if (sclk_fall && cnt_q != 5'd16) begin
                    // The fall right after the 16th rise must keep bit7,
                    // which was already driven when the header completed.
                    msh_d  = {msh_q[6:0], 1'b0};
                    miso_d = msh_q[6];
                end
            end

            ST_DONE: begin
                if (sclk_rise) begin
                    if (cnt_q == 5'd24) begin
                        over_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
        endcase

        // cs rise overrides everything; uses this cycle's count so a 24th
        // rise seen in the same clk still completes as a valid frame.
        if (state_q != ST_IDLE && cs_rise) begin
            state_d  = ST_IDLE;
            miso_d   = 1'b0;
            msh_d    = '0;
            rd_vld_d = 1'b0;
            if (!errs_q && !ferr_d && (cnt_d != 5'd24 || over_d)) begin
                ferr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s_q  <= '0;
            cs_s_q    <= '0;
            mosi_s_q  <= '0;
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            over_q    <= 1'b0;
            errs_q    <= 1'b0;
            msh_q     <= '0;
            miso_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_vld_q  <= 1'b0;
            ferr_q    <= 1'b0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sclk_s_q  <= {sclk_s_q[1:0], bus.spi_clk};
            cs_s_q    <= {cs_s_q[1:0], bus.cs};
            mosi_s_q  <= {mosi_s_q[0], bus.spi_mosi};
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            over_q    <= over_d;
            errs_q    <= errs_d;
            msh_q     <= msh_d;
            miso_q    <= miso_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_vld_q  <= rd_vld_d;
            ferr_q    <= ferr_d;
            if (mem_we) begin
                mem_q[shift_in[8 +: AW]] <= shift_in[7:0];
            end
        end
    end

    assign bus.spi_miso  = miso_q;
    assign bus.wr_vld    = wr_vld_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_spi_hmc7044_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_hmc7044_slave
// Drives SPI mode-0 frames at spi_clk = clk/10 and compares the responder's
// strobes, held write outputs and read-back data with a frame-level model of
// the register file.
// -----------------------------------------------------------------------------
module tb_spi_hmc7044_slave;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst_n;

    spi_hmc7044_slave_if bus ();

    spi_hmc7044_slave #(.REG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe counters, written only here.
    int n_wr  = 0;
    int n_rd  = 0;
    int n_err = 0;
    always @(negedge clk) begin
        if (bus.wr_vld)    n_wr  = n_wr + 1;
        if (bus.rd_vld)    n_rd  = n_rd + 1;
        if (bus.frame_err) n_err = n_err + 1;
    end

    // Frame-level model state.
    logic [7:0]  mdl_mem [DEPTH];
    logic [12:0] mdl_addr;
    logic [7:0]  mdl_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check_eq({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check_eq({tag, "_miso"},    32'(bus.spi_miso), 32'd0);
        check_eq({tag, "_wr_vld"},  32'(bus.wr_vld), 32'd0);
        check_eq({tag, "_rd_vld"},  32'(bus.rd_vld), 32'd0);
        check_eq({tag, "_ferr"},    32'(bus.frame_err), 32'd0);
    endtask

    // Mode-0 master: nbits rising edges; bits past 24 are random filler.
    // rst_bit >= 0 pulses rst_n low for one clk before that bit's rise.
    task automatic spi_frame(input logic [23:0] word, input int nbits,
                             input int rst_bit, output logic [7:0] rdata);
        rdata = '0;
        bus.cs = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = (i < 24) ? word[23 - i] : 1'($urandom);
            if (i == rst_bit) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check_outputs_zero("midrst");
            end
            half();
            bus.spi_clk = 1'b1;
            if (i >= 16 && i < 24) rdata = {rdata[6:0], bus.spi_miso};
            half();
            bus.spi_clk = 1'b0;
        end
        half();
        bus.cs = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [23:0] word,
                             input int nbits, input int rst_bit);
        logic        rw;
        logic [1:0]  w;
        logic [12:0] a;
        logic [7:0]  d;
        int          exp_wr, exp_rd, exp_err;
        logic [7:0]  exp_rdata, got_rdata;
        int          wr0, rd0, er0;

        rw = word[23];
        w  = word[22:21];
        a  = word[20:8];
        d  = word[7:0];
        exp_err   = (nbits != 24 || w != 2'b00) ? 1 : 0;
        exp_wr    = (!rw && w == 2'b00 && nbits >= 24) ? 1 : 0;
        exp_rd    = (rw && w == 2'b00 && nbits >= 16) ? 1 : 0;
        exp_rdata = (32'(a) < DEPTH) ? mdl_mem[a] : 8'h00;

        wr0 = n_wr; rd0 = n_rd; er0 = n_err;
        spi_frame(word, nbits, rst_bit, got_rdata);

        if (rst_bit >= 0 && rst_bit < nbits) begin
            // Reset wipes everything; the rest of the frame is ignored.
            exp_wr = 0; exp_rd = 0; exp_err = 0;
            for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = 8'h00;
            mdl_addr = '0;
            mdl_data = '0;
        end else if (exp_wr != 0) begin
            mdl_addr = a;
            mdl_data = d;
            if (32'(a) < DEPTH) mdl_mem[a] = d;
        end

        check_eq({tag, "_wr_vld_cnt"}, 32'(n_wr - wr0), 32'(exp_wr));
        check_eq({tag, "_rd_vld_cnt"}, 32'(n_rd - rd0), 32'(exp_rd));
        check_eq({tag, "_ferr_cnt"},   32'(n_err - er0), 32'(exp_err));
        check_eq({tag, "_wr_addr"},    32'(bus.wr_addr), 32'(mdl_addr));
        check_eq({tag, "_wr_data"},    32'(bus.wr_data), 32'(mdl_data));
        check_eq({tag, "_miso_idle"},  32'(bus.spi_miso), 32'd0);
        if (exp_rd != 0 && nbits >= 24)
            check_eq({tag, "_rdata"}, 32'(got_rdata), 32'(exp_rdata));
    endtask

    logic [12:0] ra;
    logic        rrw;
    logic [1:0]  rww;
    int          nb;

    initial begin
        rst_n        = 1'b0;
        bus.cs       = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = 8'h00;
        mdl_addr = '0;
        mdl_data = '0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        run_frame("wr1",     24'h00015A, 24, -1);
        run_frame("wrC8",    24'h00C83C, 24, -1);
        run_frame("rdC8",    24'h80C800, 24, -1);
        run_frame("wr07",    24'h0007AB, 24, -1);
        run_frame("short12", 24'h0007CD, 12, -1);
        run_frame("rd07",    24'h800700, 24, -1);
        run_frame("werr",    24'h2005FF, 24, -1);
        run_frame("rd05",    24'h800500, 24, -1);
        run_frame("rd1FFF",  24'h9FFF00, 24, -1);
        run_frame("wrOOR",   24'h1FFF42, 24, -1);
        run_frame("rderr",   24'hC00300, 24, -1);
        run_frame("over26",  24'h001077, 26, -1);
        run_frame("rd10",    24'h801000, 24, -1);
        run_frame("rstmid",  24'h000999, 24, 10);
        run_frame("rd01",    24'h800100, 24, -1);
        run_frame("wr02",    24'h000211, 24, -1);
        run_frame("rd02",    24'h800200, 24, -1);

        for (int k = 0; k < 40; k++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
            rrw = 1'($urandom);
            rww = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            nb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 26)) : 24;
            run_frame("rand", {rrw, rww, ra, 8'($urandom)}, nb, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
